// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IF) and the
// data path (DM). Round-robin grant, a single transaction in flight, variable
// memory latency through mem_ready, and an optional watchdog that aborts an
// access the memory never completes.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_rd,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_cs,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          timeout_err
);

  // Watchdog counter is wide enough to hold TIMEOUT itself; at least one bit.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Count value seen in the last BUSY cycle before the access is declared hung.
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic          WD_ON   = (TIMEOUT != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } state_t;

  state_t        state_r;
  logic          last_grant_dm_r;  // 1 = last grant went to DM, 0 = to IF
  logic [CW-1:0] wd_cnt_r;

  logic if_elig_s;
  logic dm_elig_s;
  logic grant_if_s;
  logic grant_dm_s;
  logic expire_s;

  // A requester whose ack is high this cycle is dropping its request, so it
  // must not be granted again on the stale level.
  assign if_elig_s = if_req & ~if_ack;
  assign dm_elig_s = dm_req & ~dm_ack;

  // The watchdog fires when the current BUSY cycle is the TIMEOUT-th without ready.
  assign expire_s = WD_ON & (wd_cnt_r == TO_LAST);

  // Round-robin pick between the eligible requesters (only used in IDLE).
  always_comb begin
    grant_if_s = 1'b0;
    grant_dm_s = 1'b0;
    if (if_elig_s && dm_elig_s) begin
      if (last_grant_dm_r) begin
        grant_if_s = 1'b1;
      end else begin
        grant_dm_s = 1'b1;
      end
    end else if (if_elig_s) begin
      grant_if_s = 1'b1;
    end else if (dm_elig_s) begin
      grant_dm_s = 1'b1;
    end else begin
      grant_if_s = 1'b0;
      grant_dm_s = 1'b0;
    end
  end

  // Arbiter FSM with all outputs registered; acks and error are one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      last_grant_dm_r <= 1'b0;
      wd_cnt_r        <= {CW{1'b0}};
      if_ack          <= 1'b0;
      if_rdata        <= {DW{1'b0}};
      dm_ack          <= 1'b0;
      dm_rdata        <= {DW{1'b0}};
      mem_cs          <= 1'b0;
      mem_rd          <= 1'b0;
      mem_addr        <= {AW{1'b0}};
      mem_wdata       <= {DW{1'b0}};
      timeout_err     <= 1'b0;
    end else begin
      if_ack      <= 1'b0;
      dm_ack      <= 1'b0;
      timeout_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_if_s) begin
            state_r         <= ST_BUSY_IF;
            mem_cs          <= 1'b1;
            mem_rd          <= 1'b1;
            mem_addr        <= if_addr;
            last_grant_dm_r <= 1'b0;
            wd_cnt_r        <= {CW{1'b0}};
          end else if (grant_dm_s) begin
            state_r         <= ST_BUSY_DM;
            mem_cs          <= 1'b1;
            mem_rd          <= dm_rd;
            mem_addr        <= dm_addr;
            mem_wdata       <= dm_wdata;
            last_grant_dm_r <= 1'b1;
            wd_cnt_r        <= {CW{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY_IF: begin
          if (mem_ready) begin
            state_r  <= ST_IDLE;
            mem_cs   <= 1'b0;
            if_ack   <= 1'b1;
            if_rdata <= mem_rdata;
          end else if (expire_s) begin
            state_r     <= ST_IDLE;
            mem_cs      <= 1'b0;
            if_ack      <= 1'b1;
            timeout_err <= 1'b1;
            if_rdata    <= {DW{1'b0}};
          end else if (wd_cnt_r != CNT_MAX) begin
            wd_cnt_r <= wd_cnt_r + CNT_ONE;
          end else begin
            wd_cnt_r <= wd_cnt_r;
          end
        end
        ST_BUSY_DM: begin
          if (mem_ready) begin
            state_r <= ST_IDLE;
            mem_cs  <= 1'b0;
            dm_ack  <= 1'b1;
            // Only reads update the data returned to the data path.
            if (mem_rd) begin
              dm_rdata <= mem_rdata;
            end else begin
              dm_rdata <= dm_rdata;
            end
          end else if (expire_s) begin
            state_r     <= ST_IDLE;
            mem_cs      <= 1'b0;
            dm_ack      <= 1'b1;
            timeout_err <= 1'b1;
            dm_rdata    <= {DW{1'b0}};
          end else if (wd_cnt_r != CNT_MAX) begin
            wd_cnt_r <= wd_cnt_r + CNT_ONE;
          end else begin
            wd_cnt_r <= wd_cnt_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mem_cs  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter with a transaction-level
// reference model compared every cycle, plus hand-computed literal checks.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_rd;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_cs;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // memory responder configuration
  int            wait_cfg = 0;        // wait states before ready; -1 = never
  logic          idle_ready_cfg = 1'b0;
  logic [DW-1:0] rdata_cfg = '0;
  int            busy_cyc = 0;
  int            n_txn = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_rd(dm_rd), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int            m_owner;   // 0 = nobody, 1 = IF, 2 = DM
  int            m_wait;    // BUSY cycles already spent without ready
  logic          m_last_dm;
  logic          m_cs, m_rd, m_if_ack, m_dm_ack, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_dm_rdata;

  function automatic int pick(input logic i_ok, input logic d_ok, input logic last_dm);
    if (i_ok && d_ok) return last_dm ? 1 : 2;
    if (i_ok) return 1;
    if (d_ok) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= 0; m_wait <= 0; m_last_dm <= 1'b0;
      m_cs <= 1'b0; m_rd <= 1'b0; m_if_ack <= 1'b0; m_dm_ack <= 1'b0; m_err <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_if_rdata <= '0; m_dm_rdata <= '0;
    end else begin
      m_if_ack <= 1'b0; m_dm_ack <= 1'b0; m_err <= 1'b0;
      if (m_owner == 0) begin
        case (pick(if_req && !m_if_ack, dm_req && !m_dm_ack, m_last_dm))
          1: begin
            m_owner <= 1; m_wait <= 0; m_cs <= 1'b1; m_rd <= 1'b1;
            m_addr <= if_addr; m_last_dm <= 1'b0;
          end
          2: begin
            m_owner <= 2; m_wait <= 0; m_cs <= 1'b1; m_rd <= dm_rd;
            m_addr <= dm_addr; m_wdata <= dm_wdata; m_last_dm <= 1'b1;
          end
          default: ;
        endcase
      end else if (mem_ready) begin
        m_owner <= 0; m_cs <= 1'b0;
        if (m_owner == 1) begin
          m_if_ack <= 1'b1; m_if_rdata <= mem_rdata;
        end else begin
          m_dm_ack <= 1'b1;
          if (m_rd) m_dm_rdata <= mem_rdata;
        end
      end else if (TO > 0 && m_wait + 1 >= TO) begin
        m_owner <= 0; m_cs <= 1'b0; m_err <= 1'b1;
        if (m_owner == 1) begin
          m_if_ack <= 1'b1; m_if_rdata <= '0;
        end else begin
          m_dm_ack <= 1'b1; m_dm_rdata <= '0;
        end
      end else begin
        m_wait <= m_wait + 1;
      end
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check1("model mem_cs", mem_cs, m_cs);
      check1("model mem_rd", mem_rd, m_rd);
      check32("model mem_addr", mem_addr, m_addr);
      check32("model mem_wdata", mem_wdata, m_wdata);
      check1("model if_ack", if_ack, m_if_ack);
      check1("model dm_ack", dm_ack, m_dm_ack);
      check1("model timeout_err", timeout_err, m_err);
      check32("model if_rdata", if_rdata, m_if_rdata);
      check32("model dm_rdata", dm_rdata, m_dm_rdata);
    end
  end

  // memory responder: ready after wait_cfg wait states of each access
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_cs) begin
        busy_cyc++;
        if (busy_cyc == 1) n_txn++;
        mem_ready = (wait_cfg >= 0) && (busy_cyc == wait_cfg + 1);
      end else begin
        busy_cyc = 0;
        mem_ready = idle_ready_cfg;
      end
      mem_rdata = rdata_cfg;
    end
  end

  // safety net against a hung run
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int txn0;

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_rd = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // reset state
    check1("rst mem_cs", mem_cs, 1'b0);
    check1("rst if_ack", if_ack, 1'b0);
    check1("rst dm_ack", dm_ack, 1'b0);
    check1("rst timeout_err", timeout_err, 1'b0);
    check32("rst mem_addr", mem_addr, 32'h0);
    check32("rst if_rdata", if_rdata, 32'h0);

    // tie after reset: DM, IF, DM
    wait_cfg = 0; rdata_cfg = 32'h1111_2222;
    if_addr = 32'h200; dm_addr = 32'h300; dm_rd = 1'b1; dm_wdata = 32'h0;
    if_req = 1'b1; dm_req = 1'b1;
    tick();
    check1("tie c1 mem_cs", mem_cs, 1'b1);
    check32("tie first grant DM", mem_addr, 32'h300);
    tick();
    check1("tie c2 dm_ack", dm_ack, 1'b1);
    check32("tie c2 dm_rdata", dm_rdata, 32'h1111_2222);
    tick();
    check32("tie second grant IF", mem_addr, 32'h200);
    check1("tie c3 mem_rd", mem_rd, 1'b1);
    tick();
    check1("tie c4 if_ack", if_ack, 1'b1);
    tick();
    check32("tie third grant DM", mem_addr, 32'h300);
    check1("tie c5 mem_cs", mem_cs, 1'b1);
    if_req = 1'b0;
    tick();
    check1("tie c6 dm_ack", dm_ack, 1'b1);
    dm_req = 1'b0;
    tick();
    check1("tie c7 idle", mem_cs, 1'b0);

    // single IF read, zero wait
    rdata_cfg = 32'hDEAD_BEEF; if_addr = 32'h100; if_req = 1'b1;
    check1("ifrd c0 mem_cs", mem_cs, 1'b0);
    tick();
    check1("ifrd c1 mem_cs", mem_cs, 1'b1);
    check32("ifrd c1 mem_addr", mem_addr, 32'h100);
    check1("ifrd c1 if_ack", if_ack, 1'b0);
    tick();
    check1("ifrd c2 if_ack", if_ack, 1'b1);
    check32("ifrd c2 if_rdata", if_rdata, 32'hDEAD_BEEF);
    check1("ifrd c2 mem_cs", mem_cs, 1'b0);
    if_req = 1'b0;
    tick();
    check1("ifrd c3 if_ack", if_ack, 1'b0);
    check32("ifrd c3 if_rdata held", if_rdata, 32'hDEAD_BEEF);

    // DM write, 3 wait states (ready lands on the watchdog expiry cycle)
    wait_cfg = 3; dm_rd = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h1234_5678; dm_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check1("dmwr busy mem_cs", mem_cs, 1'b1);
      check1("dmwr busy mem_rd", mem_rd, 1'b0);
      check32("dmwr busy mem_wdata", mem_wdata, 32'h1234_5678);
      check1("dmwr busy dm_ack", dm_ack, 1'b0);
    end
    tick();
    check1("dmwr ack", dm_ack, 1'b1);
    check1("dmwr no err", timeout_err, 1'b0);
    check32("dmwr dm_rdata unchanged", dm_rdata, 32'h1111_2222);
    dm_req = 1'b0;
    tick();
    check1("dmwr after mem_cs", mem_cs, 1'b0);

    // watchdog abort on IF
    wait_cfg = -1; rdata_cfg = 32'hCAFE_F00D; if_addr = 32'h104; if_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check1("wd busy mem_cs", mem_cs, 1'b1);
      check1("wd busy if_ack", if_ack, 1'b0);
    end
    tick();
    check1("wd if_ack", if_ack, 1'b1);
    check1("wd timeout_err", timeout_err, 1'b1);
    check32("wd if_rdata zero", if_rdata, 32'h0);
    check1("wd mem_cs", mem_cs, 1'b0);
    if_req = 1'b0;
    tick();
    check1("wd after mem_cs", mem_cs, 1'b0);
    check1("wd after err", timeout_err, 1'b0);

    // ready on the expiry cycle wins
    wait_cfg = 3; rdata_cfg = 32'hA5A5_5A5A; if_req = 1'b1;
    repeat (5) tick();
    check1("wdok if_ack", if_ack, 1'b1);
    check1("wdok no err", timeout_err, 1'b0);
    check32("wdok if_rdata", if_rdata, 32'hA5A5_5A5A);
    if_req = 1'b0;
    tick();

    // request held through the ack cycle: exactly one transaction
    wait_cfg = 0; rdata_cfg = 32'h0BAD_F00D; if_addr = 32'h108;
    txn0 = n_txn;
    if_req = 1'b1;
    tick();
    tick();
    check1("hold c2 if_ack", if_ack, 1'b1);
    tick();
    check1("hold c3 no regrant", mem_cs, 1'b0);
    if_req = 1'b0;
    tick();
    check1("hold c4 mem_cs", mem_cs, 1'b0);
    check32("hold single txn", 32'(n_txn - txn0), 32'd1);

    // mem_ready while idle is ignored
    idle_ready_cfg = 1'b1;
    repeat (3) begin
      tick();
      check1("idle rdy if_ack", if_ack, 1'b0);
      check1("idle rdy dm_ack", dm_ack, 1'b0);
    end
    idle_ready_cfg = 1'b0;
    tick();

    // reset in the middle of a DM access
    wait_cfg = 10; dm_rd = 1'b1; dm_addr = 32'h80; dm_req = 1'b1;
    tick();
    check1("rstm c1 mem_cs", mem_cs, 1'b1);
    tick();
    #1 rst_n = 1'b0;
    #1;
    check1("rstm async mem_cs", mem_cs, 1'b0);
    check1("rstm no dm_ack", dm_ack, 1'b0);
    dm_req = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    check32("rstm dm_rdata cleared", dm_rdata, 32'h0);
    repeat (2) begin
      tick();
      check1("rstm quiet dm_ack", dm_ack, 1'b0);
      check1("rstm quiet err", timeout_err, 1'b0);
    end
    wait_cfg = 0; rdata_cfg = 32'h5555_AAAA; dm_addr = 32'h84; dm_req = 1'b1;
    tick();
    check32("rstm new mem_addr", mem_addr, 32'h84);
    tick();
    check1("rstm new dm_ack", dm_ack, 1'b1);
    check32("rstm new dm_rdata", dm_rdata, 32'h5555_AAAA);
    dm_req = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
